register_file: RTL



---
 rtl/register_file.sv | 77 +++++++
 1 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 MIPS register file, two combinational reads, one write, optional bypass
module register_file #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_RESET = 32'h00003FFC,
    parameter logic [DATA_WIDTH-1:0] GP_RESET = 32'h00001800,
    parameter int                  BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_active;

    function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
        if (idx == 29)      return SP_RESET;
        else if (idx == 28) return GP_RESET;
        else                return '0;
    endfunction

    assign wr_active = reg_write && (write_reg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_active) begin
            regs_d[write_reg] = write_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= reset_value(i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Forwarding lets write-back and decode share a cycle; $zero always reads 0.
    always_comb begin
        read_data1 = '0;
        if (read_reg1 != '0) begin
            if ((BYPASS != 0) && wr_active && (read_reg1 == write_reg)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = regs_q[read_reg1];
            end
        end
    end

    always_comb begin
        read_data2 = '0;
        if (read_reg2 != '0) begin
            if ((BYPASS != 0) && wr_active && (read_reg2 == write_reg)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = regs_q[read_reg2];
            end
        end
    end

endmodule
